multi_key_filter: RTL

MULTI_KEY_FILTER -- requirements
Module: multi_key_filter

---
 rtl/multi_key_filter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multi_key_filter.sv
// Multi-channel key debouncer with press/release edge pulses, a stretched
// press pulse and an optional long-press pulse.
// Latency: raw key change held stable -> key_press/key_release after CNT_MAX+2 cycles.
// Backpressure: none; outputs are free-running registered pulses/levels.
//
// Ports:
//   sys_clk, sys_rst     : clock and synchronous active-high reset
//   key[KEY_NUM]         : raw asynchronous key lines, active-low
//   key_level            : debounced state per channel, 1 = pressed
//   key_press/release    : one-cycle pulses on debounced edges
//   key_hold             : press pulse stretched to PULSE_LEN cycles
//   key_long             : one-cycle long-press pulse
// Optional feature macro: KEY_LONG_PRESS_EN enables the long-press counter;
// without it key_long is constant 0.
module multi_key_filter #(
  parameter int KEY_NUM   = 4,
  parameter int CNT_MAX   = 1_000_000,
  parameter int PULSE_LEN = 100_000,
  parameter int LONG_MAX  = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_hold,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int CW = $clog2(CNT_MAX);
  localparam int HW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(PULSE_LEN - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  // Synchronizer stores the raw (active-low) level so reset loads "released".
  logic [KEY_NUM-1:0] sync1_q, sync1_d;
  logic [KEY_NUM-1:0] sync2_q, sync2_d;
  logic [KEY_NUM-1:0] level_q, level_d;
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] release_q, release_d;
  logic [KEY_NUM-1:0] hold_q, hold_d;
  logic [CW-1:0]      cnt_q [KEY_NUM];
  logic [CW-1:0]      cnt_d [KEY_NUM];
  logic [HW-1:0]      hcnt_q [KEY_NUM];
  logic [HW-1:0]      hcnt_d [KEY_NUM];

  logic [KEY_NUM-1:0] pressed;
  logic [KEY_NUM-1:0] mismatch;

  assign pressed  = ~sync2_q;
  assign mismatch = pressed ^ level_q;

  always_comb begin
    sync1_d   = key;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = hold_q;
    for (int i = 0; i < KEY_NUM; i++) begin
      cnt_d[i]  = '0;
      hcnt_d[i] = hcnt_q[i];
      // Counter only runs while the synchronized input disagrees with the
      // debounced level; any agreement restarts the stability window.
      if (mismatch[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = pressed[i];
          press_d[i]   = pressed[i];
          release_d[i] = ~pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      // A new press reloads the stretch window even if already stretching.
      if (press_d[i]) begin
        hold_d[i] = 1'b1;
        hcnt_d[i] = HOLD_LAST;
      end else if (hold_q[i]) begin
        if (hcnt_q[i] == '0) hold_d[i] = 1'b0;
        else                 hcnt_d[i] = hcnt_q[i] - HOLD_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        cnt_q[i]  <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      for (int i = 0; i < KEY_NUM; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_hold    = hold_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
  localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_MAX);
  localparam logic [LW-1:0] LONG_ONE  = LW'(1);

  logic [LW-1:0]      lcnt_q [KEY_NUM];
  logic [LW-1:0]      lcnt_d [KEY_NUM];
  logic [KEY_NUM-1:0] long_q, long_d;

  // Counter climbs one past the threshold and parks there, so the pulse
  // fires once per press and re-arms only when the level drops.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      lcnt_d[i] = '0;
      if (level_q[i]) begin
        lcnt_d[i] = (lcnt_q[i] == LONG_TOP) ? lcnt_q[i] : lcnt_q[i] + LONG_ONE;
        long_d[i] = (lcnt_q[i] == LONG_LAST);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      long_q <= '0;
      for (int i = 0; i < KEY_NUM; i++) lcnt_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < KEY_NUM; i++) lcnt_q[i] <= lcnt_d[i];
    end
  end

  assign key_long = long_q;
`else
  assign key_long = '0;
`endif

endmodule
